serial_adder_controller: RTL

Bit-serial N-bit adder/subtractor that time-multiplexes one instance of the 1-bit `Full_Adder_Structural_Verilog` cell over WIDTH clock cycles. A start/done handshake sequences each operation. The block holds the inter-bit carry in a flip-flop and shifts operands LSB-first through the shared cell. It sits between the arithmetic test harness and the structural full adder, and is the first clocked consumer of that cell.

---
 rtl/serial_adder_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/serial_adder_controller.sv
// Bit-serial WIDTH-bit adder/subtractor: one shared full-adder cell processes
// operands LSB-first over WIDTH RUN cycles, sequenced by a start/done handshake.

module Full_Adder_Structural_Verilog (
  input  logic X1,
  input  logic X2,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  logic x12, a12, ac;

  xor g_x1 (x12, X1, X2);
  xor g_x2 (S, x12, Cin);
  and g_a1 (a12, X1, X2);
  and g_a2 (ac, x12, Cin);
  or  g_o1 (Cout, a12, ac);
endmodule

module serial_adder_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s, fa_co;

  // Subtraction is a + ~b + 1: B is inverted here, the +1 is preloaded into carry.
  Full_Adder_Structural_Verilog u_fa (
    .X1  (a_sh_q[0]),
    .X2  (b_sh_q[0] ^ sub_q),
    .Cin (carry_q),
    .S   (fa_s),
    .Cout(fa_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          sub_d   = sub;
          carry_d = sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          // Result is published only here so sum stays stable between dones.
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          ovf_d   = fa_co ^ carry_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule
